// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// Build option MC_PERF_CNT_EN adds cycle/retire counters to the top.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_R_EXEC,
    S_R_WB,
    S_BRANCH,
    S_ADDI_EXEC,
    S_ADDI_WB,
    S_JUMP,
    S_FAULT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_OPCODE = 2'b01;
  localparam logic [1:0] FC_FUNCT  = 2'b10;
  localparam logic [1:0] FC_BUS    = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_source;
    logic       fault;
  } ctrl_t;

  function automatic logic is_final(input state_t s,
                                    input logic rdy);
    return (s == S_MEM_WB) || (s == S_R_WB) ||
           (s == S_ADDI_WB) || (s == S_JUMP) ||
           (s == S_BRANCH) || ((s == S_MEM_WR) && rdy);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct to ALU control decode with illegal-funct flag.
// Combinational; shared with the single-cycle control unit.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_AND;
    illegal     = 1'b0;
    unique case (1'b1)
      (funct == FN_ADD): alu_control = ALU_ADD;
      (funct == FN_SUB): alu_control = ALU_SUB;
      (funct == FN_AND): alu_control = ALU_AND;
      (funct == FN_OR):  alu_control = ALU_OR;
      (funct == FN_SLT): alu_control = ALU_SLT;
      default:           illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control FSM with memory-ready stall and bus timeout.
// Define MC_PERF_CNT_EN to add cycle_count/instr_retired outputs.
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_control,
  output logic [1:0]  pc_source,
  output logic        fault,
  output logic [1:0]  fault_code
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_retired
`endif
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] fc, fc_n;
  ctrl_t      c;
  logic [2:0] dec_alu;
  logic       dec_bad;

  // zero only gates the PC in the datapath
  logic unused_zero;
  assign unused_zero = zero;

  mc_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_control (dec_alu),
    .illegal     (dec_bad)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RESET;
      cnt   <= '0;
      fc    <= FC_NONE;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      fc    <= fc_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    fc_n    = fc;
    c       = '0;
    unique case (state)
      S_RESET: state_n = S_FETCH;
      S_FETCH: begin
        c.mem_read    = 1'b1;
        c.alu_src_b   = SRCB_FOUR;
        c.alu_control = ALU_ADD;
        c.pc_source   = PCS_ALU;
        c.ir_write    = mem_ready;
        c.pc_write    = mem_ready;
        if (mem_ready) begin
          state_n = S_DECODE;
        end else if (cnt == WAIT_LAST) begin
          state_n = S_FAULT;
          fc_n    = FC_BUS;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_DECODE: begin
        c.alu_src_b   = SRCB_IMM_SH;
        c.alu_control = ALU_ADD;
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):    state_n = S_MEM_ADDR;
          (opcode == OP_RTYPE): state_n = S_R_EXEC;
          (opcode == OP_BEQ):   state_n = S_BRANCH;
          (opcode == OP_ADDI):  state_n = S_ADDI_EXEC;
          (opcode == OP_J):     state_n = S_JUMP;
          default: begin
            state_n = S_FAULT;
            fc_n    = FC_OPCODE;
          end
        endcase
      end
      S_MEM_ADDR: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = ALU_ADD;
        state_n = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
        if (mem_ready) begin
          state_n = S_MEM_WB;
        end else if (cnt == WAIT_LAST) begin
          state_n = S_FAULT;
          fc_n    = FC_BUS;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        state_n = S_FETCH;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
        if (mem_ready) begin
          state_n = S_FETCH;
        end else if (cnt == WAIT_LAST) begin
          state_n = S_FAULT;
          fc_n    = FC_BUS;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_R_EXEC: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_B;
        c.alu_control = dec_alu;
        if (dec_bad) begin
          state_n = S_FAULT;
          fc_n    = FC_FUNCT;
        end else begin
          state_n = S_R_WB;
        end
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        state_n = S_FETCH;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_control   = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCS_ALUOUT;
        state_n = S_FETCH;
      end
      S_ADDI_EXEC: begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = ALU_ADD;
        state_n = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        c.reg_write = 1'b1;
        state_n = S_FETCH;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JUMP;
        state_n = S_FETCH;
      end
      S_FAULT: c.fault = 1'b1;
      default: state_n = S_FAULT;
    endcase
  end

  assign pc_write      = c.pc_write;
  assign pc_write_cond = c.pc_write_cond;
  assign i_or_d        = c.i_or_d;
  assign mem_read      = c.mem_read;
  assign mem_write     = c.mem_write;
  assign ir_write      = c.ir_write;
  assign mem_to_reg    = c.mem_to_reg;
  assign reg_dst       = c.reg_dst;
  assign reg_write     = c.reg_write;
  assign alu_src_a     = c.alu_src_a;
  assign alu_src_b     = c.alu_src_b;
  assign alu_control   = c.alu_control;
  assign pc_source     = c.pc_source;
  assign fault         = c.fault;
  assign fault_code    = fc;

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_count   <= '0;
      instr_retired <= '0;
    end else begin
      if (state != S_RESET && state != S_FAULT)
        cycle_count <= cycle_count + 32'd1;
      if (is_final(state, mem_ready))
        instr_retired <= instr_retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed table-driven bench for multicycle_control_fsm (WAIT_MAX=4).
// Outputs are checked 1 time unit after inputs change on the falling edge.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read;
  logic       mem_write, ir_write, mem_to_reg, reg_dst;
  logic       reg_write, alu_src_a, fault;
  logic [1:0] alu_src_b, pc_source, fault_code;
  logic [2:0] alu_control;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.WAIT_MAX(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_control   (alu_control),
    .pc_source     (pc_source),
    .fault         (fault),
    .fault_code    (fault_code)
  );

  logic [19:0] got;
  assign got = {pc_write, pc_write_cond, i_or_d, mem_read,
                mem_write, ir_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, alu_src_b, alu_control,
                pc_source, fault, fault_code};

  function automatic logic [19:0] mk(
    input logic pcw, pcwc, iord, mr, mw, irw,
    input logic m2r, rd, rw, asa,
    input logic [1:0] asb,
    input logic [2:0] alu,
    input logic [1:0] pcs,
    input logic f,
    input logic [1:0] fc);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw,
            asa, asb, alu, pcs, f, fc};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        mr;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];

  logic [19:0] e_zero, e_fetch, e_fwait, e_dec, e_maddr;
  logic [19:0] e_mrd, e_mwb, e_mwr, e_rwb, e_br;
  logic [19:0] e_aex, e_awb, e_j;

  function automatic logic [19:0] e_rex(input logic [2:0] alu);
    return mk(0,0,0,0,0,0,0,0,0,1,2'b00,alu,2'b00,0,2'b00);
  endfunction

  function automatic logic [19:0] e_flt(input logic [1:0] fc);
    return mk(0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1,fc);
  endfunction

  task automatic check(input string name, input logic [19:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s: got %05h expected %05h", name, got, exp);
    else
      passed++;
  endtask

  task automatic step(input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr,
                      input logic [19:0] exp, input string name);
    @(negedge clk);
    opcode = op;
    funct = fn;
    zero = z;
    mem_ready = mr;
    #1;
    check(name, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_low", e_zero);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("s_reset", e_zero);
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic [19:0] exp);
    vecs.push_back('{op, fn, z, 1'b1, exp});
  endtask

  initial begin
    e_zero  = '0;
    e_fetch = mk(1,0,0,1,0,1,0,0,0,0,2'b01,3'b010,2'b00,0,2'b00);
    e_fwait = mk(0,0,0,1,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,2'b00);
    e_dec   = mk(0,0,0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,2'b00);
    e_maddr = mk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,2'b00);
    e_mrd   = mk(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,2'b00);
    e_mwb   = mk(0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0,2'b00);
    e_mwr   = mk(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,2'b00);
    e_rwb   = mk(0,0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,2'b00);
    e_br    = mk(0,1,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,2'b00);
    e_aex   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,2'b00);
    e_awb   = mk(0,0,0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,2'b00);
    e_j     = mk(1,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0,2'b00);

    // lw: 5 cycles
    add(6'b100011, 6'h00, 0, e_fetch);
    add(6'b100011, 6'h00, 0, e_dec);
    add(6'b100011, 6'h00, 0, e_maddr);
    add(6'b100011, 6'h00, 0, e_mrd);
    add(6'b100011, 6'h00, 0, e_mwb);
    // R sub: 4 cycles
    add(6'b000000, 6'b100010, 0, e_fetch);
    add(6'b000000, 6'b100010, 0, e_dec);
    add(6'b000000, 6'b100010, 0, e_rex(3'b110));
    add(6'b000000, 6'b100010, 0, e_rwb);
    // beq zero=1: 3 cycles
    add(6'b000100, 6'h00, 1, e_fetch);
    add(6'b000100, 6'h00, 1, e_dec);
    add(6'b000100, 6'h00, 1, e_br);
    // addi: 4 cycles
    add(6'b001000, 6'h00, 0, e_fetch);
    add(6'b001000, 6'h00, 0, e_dec);
    add(6'b001000, 6'h00, 0, e_aex);
    add(6'b001000, 6'h00, 0, e_awb);
    // j: 3 cycles
    add(6'b000010, 6'h00, 0, e_fetch);
    add(6'b000010, 6'h00, 0, e_dec);
    add(6'b000010, 6'h00, 0, e_j);
    // sw: 4 cycles
    add(6'b101011, 6'h00, 0, e_fetch);
    add(6'b101011, 6'h00, 0, e_dec);
    add(6'b101011, 6'h00, 0, e_maddr);
    add(6'b101011, 6'h00, 0, e_mwr);
    // R and / or / slt / add
    add(6'b000000, 6'b100100, 0, e_fetch);
    add(6'b000000, 6'b100100, 0, e_dec);
    add(6'b000000, 6'b100100, 0, e_rex(3'b000));
    add(6'b000000, 6'b100100, 0, e_rwb);
    add(6'b000000, 6'b100101, 0, e_fetch);
    add(6'b000000, 6'b100101, 0, e_dec);
    add(6'b000000, 6'b100101, 0, e_rex(3'b001));
    add(6'b000000, 6'b100101, 0, e_rwb);
    add(6'b000000, 6'b101010, 0, e_fetch);
    add(6'b000000, 6'b101010, 0, e_dec);
    add(6'b000000, 6'b101010, 0, e_rex(3'b111));
    add(6'b000000, 6'b101010, 0, e_rwb);
    add(6'b000000, 6'b100000, 0, e_fetch);
    add(6'b000000, 6'b100000, 0, e_dec);
    add(6'b000000, 6'b100000, 0, e_rex(3'b010));
    add(6'b000000, 6'b100000, 0, e_rwb);
    // back-to-back fetch after R_WB
    add(6'b100011, 6'h00, 0, e_fetch);

    do_reset();
    foreach (vecs[i])
      step(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].mr,
           vecs[i].exp, $sformatf("vec%0d", i));

    // fetch stalls 3 cycles, then completes
    do_reset();
    for (int i = 0; i < 3; i++)
      step(6'b000010, 6'h00, 0, 0, e_fwait, "fetch_wait");
    step(6'b000010, 6'h00, 0, 1, e_fetch, "fetch_done");
    step(6'b000010, 6'h00, 0, 1, e_dec, "fw_decode");
    step(6'b000010, 6'h00, 0, 1, e_j, "fw_jump");
    step(6'b000010, 6'h00, 0, 1, e_fetch, "fw_refetch");

    // store times out after WAIT_MAX wait cycles
    do_reset();
    step(6'b101011, 6'h00, 0, 1, e_fetch, "to_fetch");
    step(6'b101011, 6'h00, 0, 1, e_dec, "to_decode");
    step(6'b101011, 6'h00, 0, 1, e_maddr, "to_maddr");
    for (int i = 0; i < 4; i++)
      step(6'b101011, 6'h00, 0, 0, e_mwr, "to_mem_wr");
    step(6'b101011, 6'h00, 0, 0, e_flt(2'b11), "to_fault");
    step(6'b101011, 6'h00, 0, 1, e_flt(2'b11), "to_sticky");
    step(6'b000000, 6'b100000, 0, 1, e_flt(2'b11), "to_sticky2");

    // illegal opcode
    do_reset();
    step(6'b111111, 6'h00, 0, 1, e_fetch, "ilop_fetch");
    step(6'b111111, 6'h00, 0, 1, e_dec, "ilop_decode");
    step(6'b111111, 6'h00, 0, 1, e_flt(2'b01), "ilop_fault");
    step(6'b111111, 6'h00, 0, 1, e_flt(2'b01), "ilop_sticky");

    // illegal funct: no writeback
    do_reset();
    step(6'b000000, 6'b000000, 0, 1, e_fetch, "ilfn_fetch");
    step(6'b000000, 6'b000000, 0, 1, e_dec, "ilfn_decode");
    step(6'b000000, 6'b000000, 0, 1, e_rex(3'b000), "ilfn_exec");
    step(6'b000000, 6'b000000, 0, 1, e_flt(2'b10), "ilfn_fault");
    step(6'b000000, 6'b000000, 0, 1, e_flt(2'b10), "ilfn_sticky");

    // asynchronous reset in the middle of a load
    do_reset();
    step(6'b100011, 6'h00, 0, 1, e_fetch, "ar_fetch");
    step(6'b100011, 6'h00, 0, 1, e_dec, "ar_decode");
    step(6'b100011, 6'h00, 0, 1, e_maddr, "ar_maddr");
    step(6'b100011, 6'h00, 0, 0, e_mrd, "ar_mem_rd");
    #1;
    rst = 1'b0;
    #1;
    check("ar_async", e_zero);
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("ar_held", e_zero);
    rst = 1'b1;
    step(6'b100011, 6'h00, 0, 1, e_fetch, "ar_restart");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
